// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_pkg : shared constants for the interrupt queue controller        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package irq_pkg;

  localparam int ID_NONE     = 0;
  localparam int FIXED_PRIO  = 0;
  localparam int ROUND_ROBIN = 1;
  localparam int EDGE        = 0;
  localparam int LEVEL       = 1;
  localparam int CNT_W       = 5;

endpackage
`default_nettype wire

// File: rtl/irq_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_rr_arbiter : one-grant-per-cycle fixed / round-robin arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_rr_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 7,
  parameter int ID_W    = 3,
  parameter int RR_MODE = 0
) (
  input  logic [NUM_IRQ-1:0] i_cand,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_allow,
  output logic [NUM_IRQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_gnt_vld,
  output logic [ID_W-1:0]    o_ptr_nxt
);

  int              w_pos;
  logic [ID_W-1:0] w_idx;

  // i_ptr holds the last granted ID, so bit index i_ptr is ID i_ptr+1.
  always_comb begin
    o_gnt     = '0;
    o_gnt_id  = ID_W'(ID_NONE);
    o_gnt_vld = 1'b0;
    w_pos     = 0;
    w_idx     = '0;
    for (int off = 0; off < NUM_IRQ; off++) begin
      w_pos = (RR_MODE == ROUND_ROBIN) ? ((int'(i_ptr) + off) % NUM_IRQ) : off;
      w_idx = ID_W'(w_pos);
      if (i_allow && !o_gnt_vld && i_cand[w_idx]) begin
        o_gnt_vld    = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = w_idx + 1'b1;
      end
    end
    o_ptr_nxt = o_gnt_vld ? o_gnt_id : i_ptr;
  end

endmodule
`default_nettype wire

// File: rtl/irq_queue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_queue_ctrl : interrupt collection, arbitration and ID queue      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_queue_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ    = 7,
  parameter int ID_W       = 3,
  parameter int DEPTH      = 8,
  parameter int RR_MODE    = 0,
  parameter int LEVEL_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               eirq,
  input  logic               coal_clr,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [CNT_W-1:0]   queue_count,
  output logic [NUM_IRQ-1:0] coalesced
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);

  logic [NUM_IRQ-1:0] r_irq_q;
  logic               r_arm;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_inq;
  logic [NUM_IRQ-1:0] r_coal;
  logic [ID_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [ID_W-1:0]    r_rr_ptr;

  logic [NUM_IRQ-1:0] w_req;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_allow;
  logic [ID_W-1:0]    w_head_id;
  logic [NUM_IRQ-1:0] w_pop_oh;
  logic [NUM_IRQ-1:0] w_inq_eff;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_gnt_oh;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_ptr_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  // r_arm keeps a line that is already high at reset release from looking like an edge.
  if (LEVEL_MODE == LEVEL) begin : g_level
    assign w_req = irq_in;
  end else begin : g_edge
    assign w_req = irq_in & ~r_irq_q & {NUM_IRQ{r_arm}};
  end

  assign irq_valid   = (r_count != '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_head_id   = r_mem[r_head];
  assign w_pop       = eirq & irq_valid;
  assign w_allow     = ~w_full | w_pop;
  assign w_cand      = r_pending & irq_en;
  assign irq_id      = irq_valid ? w_head_id : ID_W'(ID_NONE);
  assign queue_count = r_count;
  assign coalesced   = r_coal;

  always_comb begin
    w_pop_oh = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      w_pop_oh[k] = w_pop && (w_head_id == ID_W'(k + 1));
    end
  end

  // The entry leaving this cycle no longer counts as queued for new requests.
  assign w_inq_eff = r_inq & ~w_pop_oh;

  irq_rr_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .i_cand    (w_cand),
    .i_ptr     (r_rr_ptr),
    .i_allow   (w_allow),
    .o_gnt     (w_gnt_oh),
    .o_gnt_id  (w_gnt_id),
    .o_gnt_vld (w_push),
    .o_ptr_nxt (w_ptr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_q   <= '0;
      r_arm     <= 1'b0;
      r_pending <= '0;
      r_inq     <= '0;
      r_coal    <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rr_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_irq_q   <= irq_in;
      r_arm     <= 1'b1;
      r_pending <= (r_pending & ~w_gnt_oh) | (w_req & ~r_pending & ~w_inq_eff);
      r_inq     <= (r_inq & ~w_pop_oh) | w_gnt_oh;
      r_coal    <= (r_coal & ~{NUM_IRQ{coal_clr}}) | (w_req & (r_pending | w_inq_eff));
      r_rr_ptr  <= w_ptr_nxt;
      if (w_push) begin
        r_mem[r_tail] <= w_gnt_id;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
